// File: rtl/laser_pkg.sv
// Framing definitions shared by the laser transmitter and receiver so both
// ends agree on line levels and receiver state names.
package laser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b0;

endpackage

// File: rtl/laser_byte_receiver_if.sv
// Receiver-side signal bundle: control/line inputs plus recovered byte outputs.
interface laser_byte_receiver_if #(
  parameter int DATA_BITS = 8,
  parameter int COUNT_W   = 16
);
  logic                 en;
  logic                 laser_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic [COUNT_W-1:0]   byte_count;
  logic                 busy;

  modport master (
    output en, laser_in,
    input  data_out, data_valid, frame_err, byte_count, busy
  );

  modport slave (
    input  en, laser_in,
    output data_out, data_valid, frame_err, byte_count, busy
  );
endinterface

// File: rtl/laser_byte_receiver_bit_synchronizer.sv
// Two-flop synchronizer for an asynchronous single-bit level.
module bit_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/laser_byte_receiver.sv
// Oversampling serial byte receiver for the photodiode line: idle low,
// start high, DATA_BITS LSB first, stop low.
module laser_byte_receiver #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int COUNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  laser_byte_receiver_if.slave  rx
);
  import laser_pkg::*;

  localparam int CTR_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CTR_W-1:0] HALF_M1 = CTR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CTR_W-1:0] FULL_M1 = CTR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic s_in;

  rx_state_t            state_q, state_d;
  logic [CTR_W-1:0]     bit_ctr_q, bit_ctr_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  bit_synchronizer u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx.laser_in),
    .q     (s_in)
  );

  always_comb begin
    state_d   = state_q;
    bit_ctr_d = bit_ctr_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    count_d   = count_q;

    unique case (state_q)
      IDLE: begin
        bit_ctr_d = '0;
        if (rx.en && s_in == START_LEVEL) state_d = START;
      end
      // Mid-start-bit recheck rejects short glitches and centres the sampling.
      START: begin
        if (bit_ctr_q == HALF_M1) begin
          bit_ctr_d = '0;
          bit_idx_d = '0;
          state_d   = (s_in == START_LEVEL) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (bit_ctr_q == FULL_M1) begin
          bit_ctr_d = '0;
          shift_d   = {s_in, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_IDX) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_ctr_q == FULL_M1) begin
          bit_ctr_d = '0;
          if (s_in == STOP_LEVEL) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            count_d = count_q + 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      // A stuck-on laser must go dark before another frame can start.
      WAIT_IDLE: begin
        if (s_in == IDLE_LEVEL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rx.en) begin
      state_d = IDLE;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      count_d = count_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_ctr_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_ctr_q <= bit_ctr_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign rx.data_out   = data_q;
  assign rx.data_valid = valid_q;
  assign rx.frame_err  = err_q;
  assign rx.byte_count = count_q;
  assign rx.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_laser_byte_receiver.sv
// Self-checking bench: frame-level reference model compared every cycle,
// a table of directed frames, hand-written corner sequences and random traffic.
module tb_laser_byte_receiver;
  localparam int CPB   = 8;
  localparam int HALF  = CPB / 2;
  localparam int DBITS = 8;
  localparam int LAT   = 2 + HALF + (DBITS + 1) * CPB + 1;

  logic clock;
  logic reset;

  laser_byte_receiver_if #(.DATA_BITS(8), .COUNT_W(16)) rx_if ();
  laser_byte_receiver_if #(.DATA_BITS(8), .COUNT_W(2))  rx_w_if ();

  assign rx_w_if.en       = rx_if.en;
  assign rx_w_if.laser_in = rx_if.laser_in;

  laser_byte_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(DBITS), .COUNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .rx    (rx_if)
  );

  laser_byte_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(DBITS), .COUNT_W(2)) dut_wrap (
    .clock (clock),
    .reset (reset),
    .rx    (rx_w_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_dv = 0;
  int n_fe = 0;
  int last_dv_cyc = 0;

  // Reference model: mode 0 idle, 1 in frame (anchored at detection edge), 2 waiting for dark line.
  int          m_mode = 0;
  int          m_anchor = 0;
  logic [7:0]  m_bits = '0;
  logic [7:0]  m_data = '0;
  int unsigned m_count = 0;
  logic        m_dv = 1'b0;
  logic        m_fe = 1'b0;
  logic        m_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic lin);
    logic sin;
    int off, n;
    if (rst) begin
      m_mode = 0; m_data = '0; m_count = 0; m_dv = 1'b0; m_fe = 1'b0;
      m_hist = '{1'b0, 1'b0};
      return;
    end
    sin = m_hist.pop_front();
    m_hist.push_back(lin);
    m_dv = 1'b0;
    m_fe = 1'b0;
    if (!en) m_mode = 0;
    else if (m_mode == 0) begin
      if (sin) begin m_mode = 1; m_anchor = cyc; end
    end else if (m_mode == 1) begin
      off = cyc - m_anchor;
      if (off == HALF) begin
        if (!sin) m_mode = 0;
      end else if (off > HALF && (off - HALF) % CPB == 0) begin
        n = (off - HALF) / CPB;
        if (n <= DBITS) m_bits[n-1] = sin;
        else if (!sin) begin
          m_data = m_bits; m_dv = 1'b1; m_count++; m_mode = 0;
        end else begin
          m_fe = 1'b1; m_mode = 2;
        end
      end
    end else if (!sin) m_mode = 0;
  endtask

  task automatic tick();
    model_step(reset, rx_if.en, rx_if.laser_in);
    @(posedge clock);
    @(negedge clock);
    cyc++;
    if (rx_if.data_valid === 1'b1) begin n_dv++; last_dv_cyc = cyc; end
    if (rx_if.frame_err === 1'b1) n_fe++;
    check("data_valid", rx_if.data_valid, m_dv);
    check("frame_err", rx_if.frame_err, m_fe);
    check("strobe_excl", rx_if.data_valid & rx_if.frame_err, 0);
    check("busy", rx_if.busy, (m_mode != 0));
    check("data_out", rx_if.data_out, m_data);
    check("byte_count", rx_if.byte_count, m_count[15:0]);
    check("byte_count_w2", rx_w_if.byte_count, m_count[1:0]);
  endtask

  // Frame word: bit 0 start, bits 1..8 data LSB first, bit 9 stop.
  task automatic drive_ticks(input logic [9:0] f, input int n);
    for (int t = 0; t < n; t++) begin
      rx_if.laser_in = f[t / CPB];
      tick();
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_lvl;
    int         hold_hi;
    int         gap;
    logic       exp_good;
    logic [7:0] exp_data_out;
  } vec_t;

  vec_t tbl [5];
  int   dv_at [5];

  initial begin
    int dv0, fe0, c0, k, kind;
    logic [9:0] f;

    tbl[0] = '{8'hF1, 1'b0, 0,  4, 1'b1, 8'hF1};
    tbl[1] = '{8'hF0, 1'b1, 20, 4, 1'b0, 8'hF1};
    tbl[2] = '{8'hA5, 1'b0, 0,  0, 1'b1, 8'hA5};
    tbl[3] = '{8'h3C, 1'b0, 0,  6, 1'b1, 8'h3C};
    tbl[4] = '{8'h55, 1'b0, 0,  4, 1'b1, 8'h55};

    m_hist = '{1'b0, 1'b0};
    reset = 1'b1;
    rx_if.en = 1'b1;
    rx_if.laser_in = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();

    for (int i = 0; i < 5; i++) begin
      dv0 = n_dv; fe0 = n_fe; c0 = cyc;
      drive_ticks({tbl[i].stop_lvl, tbl[i].data, 1'b1}, 10 * CPB);
      rx_if.laser_in = 1'b1;
      repeat (tbl[i].hold_hi) tick();
      rx_if.laser_in = 1'b0;
      repeat (tbl[i].gap) tick();
      check("tbl_valid_cnt", n_dv - dv0, tbl[i].exp_good);
      check("tbl_err_cnt", n_fe - fe0, !tbl[i].exp_good);
      check("tbl_data_out", rx_if.data_out, tbl[i].exp_data_out);
      check("tbl_busy_end", rx_if.busy, 0);
      if (tbl[i].exp_good) check("latency", last_dv_cyc - c0, LAT);
      dv_at[i] = last_dv_cyc;
    end
    check("b2b_spacing", dv_at[3] - dv_at[2], 10 * CPB);
    check("count_after_tbl", rx_if.byte_count, 4);

    // Short glitch on an idle line.
    dv0 = n_dv; fe0 = n_fe;
    rx_if.laser_in = 1'b1;
    repeat (3) tick();
    rx_if.laser_in = 1'b0;
    repeat (4) tick();
    check("glitch_busy", rx_if.busy, 0);
    repeat (10) tick();
    check("glitch_strobes", (n_dv - dv0) + (n_fe - fe0), 0);

    // Reset in the middle of data bit 4, then a clean frame.
    dv0 = n_dv; fe0 = n_fe;
    drive_ticks({1'b0, 8'h55, 1'b1}, 5 * CPB + 3);
    reset = 1'b1;
    rx_if.laser_in = 1'b0;
    tick();
    check("rst_data_out", rx_if.data_out, 0);
    check("rst_count", rx_if.byte_count, 0);
    check("rst_busy", rx_if.busy, 0);
    reset = 1'b0;
    repeat (6) tick();
    drive_ticks({1'b0, 8'h55, 1'b1}, 10 * CPB);
    repeat (3) tick();
    check("post_rst_data", rx_if.data_out, 8'h55);
    check("post_rst_count", rx_if.byte_count, 1);
    check("post_rst_strobes", (n_dv - dv0) + (n_fe - fe0), 1);

    // Enable dropped during data bit 2.
    dv0 = n_dv;
    f = {1'b0, 8'hC3, 1'b1};
    for (int t = 0; t < 10 * CPB; t++) begin
      if (t == 3 * CPB + 3) rx_if.en = 1'b0;
      rx_if.laser_in = f[t / CPB];
      tick();
      if (t == 3 * CPB + 3) check("en_drop_busy", rx_if.busy, 0);
    end
    rx_if.laser_in = 1'b0;
    repeat (3) tick();
    rx_if.en = 1'b1;
    repeat (3) tick();
    check("en_drop_no_dv", n_dv - dv0, 0);
    check("en_drop_data", rx_if.data_out, 8'h55);
    check("en_drop_count", rx_if.byte_count, 1);

    // Three more good bytes: the 2-bit counter wraps to zero.
    drive_ticks({1'b0, 8'h00, 1'b1}, 10 * CPB);
    drive_ticks({1'b0, 8'hFF, 1'b1}, 10 * CPB);
    drive_ticks({1'b0, 8'h81, 1'b1}, 10 * CPB);
    repeat (2) tick();
    check("wrap_count_w2", rx_w_if.byte_count, 0);
    check("wrap_count_w16", rx_if.byte_count, 4);
    check("wrap_data", rx_if.data_out, 8'h81);

    // Random traffic against the model.
    for (int r = 0; r < 16; r++) begin
      kind = $urandom_range(0, 9);
      f = {1'b0, 8'($urandom), 1'b1};
      if (kind <= 5) drive_ticks(f, 10 * CPB);
      else if (kind == 6) begin
        f[9] = 1'b1;
        drive_ticks(f, 10 * CPB);
        rx_if.laser_in = 1'b1;
        repeat ($urandom_range(0, 10)) tick();
      end else if (kind == 7) begin
        rx_if.laser_in = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
      end else if (kind == 8) begin
        k = $urandom_range(1, 70);
        for (int t = 0; t < 10 * CPB; t++) begin
          if (t == k) rx_if.en = 1'b0;
          rx_if.laser_in = f[t / CPB];
          tick();
        end
        rx_if.en = 1'b1;
      end else begin
        drive_ticks(f, $urandom_range(10, 70));
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      rx_if.laser_in = 1'b0;
      repeat ($urandom_range(0, 12)) tick();
    end
    rx_if.laser_in = 1'b0;
    repeat (20) tick();
    check("final_idle", rx_if.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/laser_byte_receiver.md
Name: laser_byte_receiver

Overview:
- Recovers serial bytes from one photodiode input driven by the laser transmitter.
- Frame format:
  - line idles low (laser off);
  - start bit is high;
  - 8 data bits follow, LSB first;
  - stop bit is low.
- Runs on CLOCK_50 and oversamples each bit period by CLKS_PER_BIT.
- Outputs the last good byte for the HEX displays, a one-cycle valid strobe, a framing-error strobe and a running byte count.

Parameters:
- CLKS_PER_BIT, 8: clock cycles per line bit (8 gives 6.25 Mbaud at 50 MHz). Must be even and >= 4.
- DATA_BITS, 8: payload bits per frame.
- COUNT_W, 16: width of the good-byte counter.

Ports:
- clock, input, 1: system clock (CLOCK_50).
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: receive enable; low forces IDLE.
- laser_in, input, 1: raw photodiode level, asynchronous to clock.
- data_out, output, DATA_BITS: last byte received with a valid stop bit. Held until the next good byte.
- data_valid, output, 1: one-cycle pulse when data_out updates.
- frame_err, output, 1: one-cycle pulse when the stop bit samples high.
- byte_count, output, COUNT_W: number of good bytes received. Wraps to 0 after all-ones.
- busy, output, 1: high whenever the state is not IDLE.

Behaviour:
- Clock and reset:
  - One clock (clock); reset is synchronous and active-high.
  - On reset, all outputs are 0: data_out=0, data_valid=0, frame_err=0, byte_count=0, busy=0. State=IDLE, synchronizer flops=0.
  - Reset asserted mid-frame aborts the frame with no strobe.
- Input synchronizer:
  - laser_in passes through a 2-flop synchronizer; all logic uses the synchronized signal s_in.
  - This adds 2 cycles of latency.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- Counters:
  - bit_ctr counts cycles within a bit, width clog2(CLKS_PER_BIT).
  - bit_idx counts data bits, width clog2(DATA_BITS+1).
- IDLE:
  - If en=1 and s_in=1, go to START and clear bit_ctr.
- START:
  - Count to CLKS_PER_BIT/2-1 (the mid-bit point).
  - If s_in=1 at that point, go to DATA and clear bit_ctr and bit_idx.
  - If s_in=0 at that point, treat it as a glitch and return to IDLE with no strobe.
- DATA:
  - Each time bit_ctr reaches CLKS_PER_BIT-1, sample s_in into the shift register MSB, shift right, and increment bit_idx.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - When bit_ctr reaches CLKS_PER_BIT-1, sample s_in.
  - If s_in=0: data_out <= shift register, data_valid=1 on the next cycle, byte_count++, go to IDLE.
  - If s_in=1: frame_err=1 on the next cycle, data_out unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until s_in=0, then go to IDLE.
  - This prevents a stuck-on laser from generating repeated frames.
- Enable:
  - en=0 in any state forces IDLE on the next cycle with no strobe.
  - data_out and byte_count are retained.
- Latency:
  - Measured from the first clock edge where laser_in=1 (start bit) to data_valid high: 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles.
  - This is 79 cycles for the defaults.
- Back-to-back frames:
  - A new start bit may begin in the cycle after the stop sample.
  - IDLE accepts it immediately, with no minimum gap beyond half of the stop bit.
- Strobes:
  - data_valid and frame_err are never high simultaneously.
  - Each is high for exactly one cycle per frame.

Decomposition:
- Package laser_pkg, holding:
  - state enum rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE};
  - constants START_LEVEL=1'b1, STOP_LEVEL=1'b0, IDLE_LEVEL=1'b0.
- The same package is shared with the transmitter so both ends agree on framing.
- Sub-module bit_synchronizer: a 2-flop synchronizer, synchronous reset to 0. Reusable for the second laser channel.
- Top level instantiates one laser_byte_receiver per laser channel.

Test Plan (CLKS_PER_BIT=8):
- Drive frame 0xF1 (start=1, bits 1,0,0,0,1,1,1,1, stop=0), 8 cycles per bit -> data_valid pulses once at cycle 79, data_out=0xF1, byte_count=1, frame_err never set.
- Drive 3-cycle high glitch on an idle line -> return to IDLE after the mid-bit check; no data_valid or frame_err; busy low again within 7 cycles.
- Drive frame 0xF0 with stop bit high, line held high for 20 more cycles -> frame_err pulses once, data_out keeps previous 0xF1, state stays WAIT_IDLE until line low, no repeat frame.
- Drive back-to-back frames 0xA5 then 0x3C with zero idle gap -> two data_valid pulses 80 cycles apart, data_out 0xA5 then 0x3C, byte_count +2.
- Assert reset at bit 4 of a frame -> all outputs 0 the next cycle; no strobe; a following clean frame 0x55 is received correctly.
- Drop en during data bit 2 -> no strobe, busy=0 next cycle, data_out and byte_count unchanged; set byte_count to 0xFFFF and receive one frame -> wraps to 0.
